// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary MAC array: loads weights, streams skewed input vectors, tracks results out.
// Latency: done pulses 2*N+M+PIPE_LAT+1 cycles after start; stall holds compute/drain and gates all data strobes.
module systolic_ctrl #(
    parameter int ARRAY_DIM = 4,
    parameter int VEC_W     = 8,
    parameter int PIPE_LAT  = 4,
    parameter int ROW_W     = $clog2(ARRAY_DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_W-1:0]     num_vec,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 w_load,
    output logic [ROW_W-1:0]     w_row,
    output logic                 d_rd,
    output logic [VEC_W-1:0]     d_addr,
    output logic [ARRAY_DIM-1:0] col_en,
    output logic                 array_en,
    output logic                 o_valid,
    output logic [VEC_W-1:0]     o_addr
);

    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [VEC_W-1:0]     m_q;
    logic [VEC_W-1:0]     d_cnt_q;
    logic [VEC_W-1:0]     o_cnt_q;
    logic [ROW_W-1:0]     w_cnt_q;
    logic [ARRAY_DIM-1:0] col_q;
    logic [PIPE_LAT-1:0]  lat_q;
    logic                 done_q;

    logic                 running;
    logic                 stall_act;
    logic                 accept;
    logic                 last_row;
    logic                 last_vec;
    logic                 o_fire;
    logic                 last_out;
    logic [ARRAY_DIM:0]   col_ext;
    logic [PIPE_LAT:0]    lat_ext;

    assign running   = (state_q == COMPUTE) || (state_q == DRAIN);
    assign stall_act = running && stall;
    assign accept    = (state_q == IDLE) && start && (num_vec != '0);
    assign last_row  = (w_cnt_q == ROW_W'(ARRAY_DIM - 1));
    assign last_vec  = (d_cnt_q == m_q - VEC_W'(1));
    assign o_fire    = lat_q[PIPE_LAT-1] && !stall_act;
    assign last_out  = o_fire && (o_cnt_q == m_q - VEC_W'(1));

    // The read strobe enters the skew chain ungated; the whole chain freezes while stalled.
    assign col_ext   = {col_q, (state_q == COMPUTE)};
    assign lat_ext   = {lat_q, col_q[ARRAY_DIM-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            d_cnt_q <= '0;
            o_cnt_q <= '0;
            w_cnt_q <= '0;
            col_q   <= '0;
            lat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && last_out;
            if (accept) begin
                m_q     <= num_vec;
                d_cnt_q <= '0;
                o_cnt_q <= '0;
                w_cnt_q <= '0;
            end
            if (state_q == LOAD_W) begin
                w_cnt_q <= last_row ? '0 : w_cnt_q + ROW_W'(1);
            end
            if ((state_q == COMPUTE) && !stall && !last_vec) begin
                d_cnt_q <= d_cnt_q + VEC_W'(1);
            end
            if (o_fire) begin
                o_cnt_q <= o_cnt_q + VEC_W'(1);
            end
            if (!stall_act) begin
                col_q <= col_ext[ARRAY_DIM-1:0];
                lat_q <= lat_ext[PIPE_LAT-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        done     = done_q;
        w_load   = (state_q == LOAD_W);
        w_row    = w_cnt_q;
        d_rd     = (state_q == COMPUTE) && !stall;
        d_addr   = d_cnt_q;
        col_en   = stall_act ? '0 : col_q;
        array_en = (state_q == LOAD_W) || (running && !stall);
        o_valid  = o_fire;
        o_addr   = o_cnt_q;
        case (state_q)
            IDLE:    if (accept)              state_d = LOAD_W;
            LOAD_W:  if (last_row)            state_d = COMPUTE;
            COMPUTE: if (!stall && last_vec)  state_d = DRAIN;
            DRAIN:   if (last_out)            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with N=4, PIPE_LAT=4; cycle k of a job is the cycle after its start edge + k-1.
module tb_systolic_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] num_vec;
    logic       stall;
    logic       busy, done, w_load, d_rd, array_en, o_valid;
    logic [1:0] w_row;
    logic [7:0] d_addr, o_addr;
    logic [3:0] col_en;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    systolic_ctrl #(.ARRAY_DIM(4), .VEC_W(8), .PIPE_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .stall(stall),
        .busy(busy), .done(done), .w_load(w_load), .w_row(w_row),
        .d_rd(d_rd), .d_addr(d_addr), .col_en(col_en), .array_en(array_en),
        .o_valid(o_valid), .o_addr(o_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},     32'(busy),     0);
        chk({tag, " done"},     32'(done),     0);
        chk({tag, " w_load"},   32'(w_load),   0);
        chk({tag, " w_row"},    32'(w_row),    0);
        chk({tag, " d_rd"},     32'(d_rd),     0);
        chk({tag, " d_addr"},   32'(d_addr),   0);
        chk({tag, " col_en"},   32'(col_en),   0);
        chk({tag, " array_en"}, 32'(array_en), 0);
        chk({tag, " o_valid"},  32'(o_valid),  0);
        chk({tag, " o_addr"},   32'(o_addr),   0);
    endtask

    // Issues start in the current cycle (cycle 0) and checks cycles 1..done_c.
    // LOAD_W is always cycles 1-4 and reads start at cycle 5.
    task automatic run_job(input string name, input int m, input int done_c, input int ov_lo,
                           input int st_lo, input int st_hi, input int ign_c, input bit col_chk);
        start   = 1'b1;
        num_vec = 8'(m);
        for (int c = 1; c <= done_c; c++) begin
            bit st;
            bit wl_e, dr_e, ov_e, ae_e;
            string t;
            @(posedge clk);
            #1;
            st      = (c >= st_lo) && (c <= st_hi);
            start   = (c == ign_c);
            num_vec = (c == ign_c) ? 8'd5 : 8'(m);
            stall   = st;
            @(negedge clk);
            t    = $sformatf("%s c%0d", name, c);
            wl_e = (c >= 1) && (c <= 4);
            dr_e = (c >= 5) && (c <= 4 + m) && !st;
            ov_e = (c >= ov_lo) && (c <= ov_lo + m - 1);
            ae_e = wl_e || ((c < done_c) && !st);
            chk({t, " busy"},     32'(busy),     32'(c < done_c));
            chk({t, " done"},     32'(done),     32'(c == done_c));
            chk({t, " w_load"},   32'(w_load),   32'(wl_e));
            chk({t, " d_rd"},     32'(d_rd),     32'(dr_e));
            chk({t, " o_valid"},  32'(o_valid),  32'(ov_e));
            chk({t, " array_en"}, 32'(array_en), 32'(ae_e));
            if (wl_e) chk({t, " w_row"},  32'(w_row),  32'(c - 1));
            if (dr_e) chk({t, " d_addr"}, 32'(d_addr), 32'(c - 5));
            if (ov_e) chk({t, " o_addr"}, 32'(o_addr), 32'(c - ov_lo));
            if (st && c > 4) chk({t, " col_en_stall"}, 32'(col_en), 0);
            if (col_chk) begin
                chk({t, " col_en0"}, 32'(col_en[0]), 32'((c >= 6) && (c <= 5 + m)));
                chk({t, " col_en3"}, 32'(col_en[3]), 32'((c >= 9) && (c <= 8 + m)));
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        num_vec = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic M=3 job: d_rd 5-7, o_valid 13-15, done 16.
        run_job("base", 3, 16, 13, 0, -1, 0, 1'b1);
        @(negedge clk);

        // Stall in cycles 10-11 pushes o_valid to 15-17 and done to 18.
        run_job("stall_drain", 3, 18, 15, 10, 11, 0, 1'b0);
        @(negedge clk);

        // Stall during LOAD_W is ignored entirely.
        run_job("stall_load", 3, 16, 13, 1, 4, 0, 1'b1);
        @(negedge clk);

        // Zero-length job is dropped.
        start   = 1'b1;
        num_vec = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("zero c%0d busy", c),   32'(busy),   0);
            chk($sformatf("zero c%0d done", c),   32'(done),   0);
            chk($sformatf("zero c%0d w_load", c), 32'(w_load), 0);
        end

        // Start while busy is ignored; a start in the done cycle is accepted.
        run_job("ignore", 3, 16, 13, 0, -1, 8, 1'b1);
        run_job("chain_m1", 1, 14, 13, 0, -1, 0, 1'b1);
        @(negedge clk);

        // Reset at edge 9 of an M=8 job (mid-COMPUTE).
        start   = 1'b1;
        num_vec = 8'd8;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 9) rst_n = 1'b0;
            @(negedge clk);
            chk($sformatf("pre_rst c%0d busy", c), 32'(busy), 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        run_job("after_rst", 2, 15, 13, 0, -1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
